// File: rtl/lrn_clause_gen_if.sv
// ---------------------------------------------------------------------------
// lrn_clause_gen_if
//   Literal stream between the learnt-clause generator and the downstream
//   clause store. It is a valid/ready handshake: a literal moves on a rising
//   clock edge where lit_valid_o and lit_ready_i are both high.
//
//   Parameter
//     IDX_W        width of a variable index, clog2(NUM_VARS) of the producer
//
//   Signals (named from the generator's point of view)
//     lit_valid_o  a literal is being offered
//     lit_ready_i  the clause store accepts the literal
//     lit_index_o  variable index of the literal
//     lit_sign_o   literal polarity, 1 = negative
//     lit_last_o   final literal of the clause
//
//   Modports
//     master  the generator (drives the literal, samples ready)
//     slave   the clause store (drives ready, samples the literal)
// ---------------------------------------------------------------------------
interface lrn_clause_gen_if #(
    parameter int IDX_W = 3
) ();
    logic             lit_valid_o;
    logic             lit_ready_i;
    logic [IDX_W-1:0] lit_index_o;
    logic             lit_sign_o;
    logic             lit_last_o;

    modport master (
        output lit_valid_o,
        output lit_index_o,
        output lit_sign_o,
        output lit_last_o,
        input  lit_ready_i
    );

    modport slave (
        input  lit_valid_o,
        input  lit_index_o,
        input  lit_sign_o,
        input  lit_last_o,
        output lit_ready_i
    );
endinterface

// File: rtl/lrn_clause_gen.sv
// ---------------------------------------------------------------------------
// lrn_clause_gen
//   Builds a learnt clause from the per-variable analysis state of a small
//   SAT engine window. On start_i (honoured only in IDLE) the variable
//   values, levels and current decision level are snapshotted. SCAN then
//   visits one variable per cycle (index 0 up to NUM_VARS-1) and, for every
//   marked variable (value[1:0] == 2'b11), records it, counts the clause
//   length and tracks the backtrack level. EMIT streams the marked literals
//   in ascending index order over a valid/ready interface with no bubbles
//   for unmarked variables, and DONE pulses done_o for one cycle.
//
//   Parameters
//     NUM_VARS     number of variables in the window            (default 8)
//     WIDTH_LVL    decision-level width                         (default 10)
//     WIDTH_C_LEN  clause-length width, clog2(NUM_VARS)+1        (default 4)
//
//   Ports
//     clk          clock, rising edge
//     rst          asynchronous, active-low reset
//     start_i      start pulse, snapshots var_value_i/var_lvl_i/cur_lvl_i
//     var_value_i  NUM_VARS x 3-bit value; bit 2 = literal sign,
//                  bits 1:0 == 2'b11 marks the variable; MSB slice = last var
//     var_lvl_i    NUM_VARS x WIDTH_LVL decision levels, same ordering
//     cur_lvl_i    current decision level
//     lit          literal stream (lrn_clause_gen_if.master)
//     clause_len_o learnt clause length, valid from scan end to next start
//     bkt_lvl_o    backtrack level, valid from scan end to next start
//     busy_o       high whenever the FSM is not IDLE
//     done_o       one-cycle completion pulse
//     err_o        non-asserting clause flag, pulses with done_o
//
//   Configuration
//     LRN_ASSERT_CHECK_EN  when defined, the scan also counts marked
//                          variables at the current level and err_o pulses
//                          with done_o unless exactly one was found (the
//                          empty clause included). When undefined, err_o is
//                          tied low and no counter is built.
// ---------------------------------------------------------------------------
module lrn_clause_gen #(
    parameter int NUM_VARS    = 8,
    parameter int WIDTH_LVL   = 10,
    parameter int WIDTH_C_LEN = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [NUM_VARS*3-1:0]         var_value_i,
    input  logic [NUM_VARS*WIDTH_LVL-1:0] var_lvl_i,
    input  logic [WIDTH_LVL-1:0]          cur_lvl_i,
    lrn_clause_gen_if.master              lit,
    output logic [WIDTH_C_LEN-1:0]        clause_len_o,
    output logic [WIDTH_LVL-1:0]          bkt_lvl_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          err_o
);

    localparam int IDX_W = $clog2(NUM_VARS);

    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_VARS - 1);
    localparam logic [WIDTH_C_LEN-1:0] LEN_MAX  = WIDTH_C_LEN'(NUM_VARS);
    localparam logic [WIDTH_C_LEN-1:0] LEN_ONE  = WIDTH_C_LEN'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    // -----------------------------------------------------------------------
    // Snapshot of the inputs taken on the accepted start edge
    // -----------------------------------------------------------------------
    logic [NUM_VARS*3-1:0]         value_reg;
    logic [NUM_VARS*WIDTH_LVL-1:0] lvl_reg;
    logic [WIDTH_LVL-1:0]          cur_lvl_reg;

    // -----------------------------------------------------------------------
    // Scan / emit datapath
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]       scan_idx_reg;
    // Marked literals that have not yet been transferred. SCAN sets bits,
    // EMIT clears the lowest one on each transfer, so the lowest set bit is
    // always the literal on offer.
    logic [NUM_VARS-1:0]    pend_reg;
    logic [WIDTH_C_LEN-1:0] len_reg;
    logic [WIDTH_LVL-1:0]   bkt_reg;

    // Per-variable views of the snapshot
    logic [NUM_VARS-1:0]  mark_vec;
    logic [NUM_VARS-1:0]  sign_vec;
    logic [WIDTH_LVL-1:0] lvl_arr [NUM_VARS];

    generate
        for (genvar gi = 0; gi < NUM_VARS; gi++) begin : g_var
            assign mark_vec[gi] = value_reg[gi*3 + 1] & value_reg[gi*3];
            assign sign_vec[gi] = value_reg[gi*3 + 2];
            assign lvl_arr[gi]  = lvl_reg[gi*WIDTH_LVL +: WIDTH_LVL];
        end
    endgenerate

    // Variable under examination this SCAN cycle
    logic                 scan_mark;
    logic [WIDTH_LVL-1:0] scan_lvl;

    assign scan_mark = mark_vec[scan_idx_reg];
    assign scan_lvl  = lvl_arr[scan_idx_reg];

    // Lowest pending literal (priority encoder, low index wins)
    logic [IDX_W-1:0] pick_idx;

    always_comb begin
        pick_idx = '0;
        for (int i = NUM_VARS - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Exactly one literal left: clearing the lowest set bit leaves nothing
    logic only_one;
    assign only_one = (pend_reg != '0) &&
                      ((pend_reg & (pend_reg - NUM_VARS'(1))) == '0);

    logic emit_xfer;
    assign emit_xfer = (state_reg == EMIT) && lit.lit_ready_i;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        lit.lit_valid_o = 1'b0;
        lit.lit_index_o = '0;
        lit.lit_sign_o  = 1'b0;
        lit.lit_last_o  = 1'b0;
        busy_o          = 1'b1;
        done_o          = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_next = SCAN;
                end
            end

            SCAN: begin
                // The last variable's mark is not in len_reg yet, so it is
                // folded in here to decide whether anything will be emitted.
                if (scan_idx_reg == LAST_IDX) begin
                    if ((len_reg != '0) || scan_mark) begin
                        state_next = EMIT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            EMIT: begin
                lit.lit_valid_o = 1'b1;
                lit.lit_index_o = pick_idx;
                lit.lit_sign_o  = sign_vec[pick_idx];
                lit.lit_last_o  = only_one;
                if (emit_xfer && only_one) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Snapshot, scan accumulators and pending-literal set
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_reg    <= '0;
            lvl_reg      <= '0;
            cur_lvl_reg  <= '0;
            scan_idx_reg <= '0;
            pend_reg     <= '0;
            len_reg      <= '0;
            bkt_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_i) begin
                        value_reg    <= var_value_i;
                        lvl_reg      <= var_lvl_i;
                        cur_lvl_reg  <= cur_lvl_i;
                        scan_idx_reg <= '0;
                        pend_reg     <= '0;
                        len_reg      <= '0;
                        bkt_reg      <= '0;
                    end
                end

                SCAN: begin
                    scan_idx_reg <= scan_idx_reg + IDX_W'(1);
                    if (scan_mark) begin
                        pend_reg[scan_idx_reg] <= 1'b1;
                        if (len_reg != LEN_MAX) begin
                            len_reg <= len_reg + LEN_ONE;
                        end
                        // Only levels strictly below the current level can
                        // be backtrack targets.
                        if ((scan_lvl < cur_lvl_reg) && (scan_lvl > bkt_reg)) begin
                            bkt_reg <= scan_lvl;
                        end
                    end
                end

                EMIT: begin
                    if (emit_xfer) begin
                        pend_reg[pick_idx] <= 1'b0;
                    end
                end

                default: begin
                end
            endcase
        end
    end

    assign clause_len_o = len_reg;
    assign bkt_lvl_o    = bkt_reg;

    // -----------------------------------------------------------------------
    // Asserting-clause check
    // -----------------------------------------------------------------------
`ifdef LRN_ASSERT_CHECK_EN
    // Marked variables at the current decision level. A proper learnt clause
    // has exactly one of them (the UIP literal).
    logic [WIDTH_C_LEN-1:0] asrt_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asrt_cnt_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && start_i) begin
                asrt_cnt_reg <= '0;
            end else if ((state_reg == SCAN) && scan_mark &&
                         (scan_lvl == cur_lvl_reg) && (asrt_cnt_reg != LEN_MAX)) begin
                asrt_cnt_reg <= asrt_cnt_reg + LEN_ONE;
            end
        end
    end

    assign err_o = (state_reg == DONE) && (asrt_cnt_reg != LEN_ONE);
`else
    assign err_o = 1'b0;
`endif

endmodule
